// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the radix-2 DIT FFT control slice.
//   - fft_state_e : sequencer states (idle, issuing butterflies, waiting for
//                   the butterfly pipeline to empty, completion pulse).
//   - stage_w     : width of the stage-select field for an N-point FFT.
//   - bfly_w      : width of the butterfly-index / twiddle-address fields.
//   - tw_index    : twiddle ROM index for a (stage, butterfly) pair.
//   No ports (package).
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_e;

  // Stage select must hold 0..log2(N)-1; never narrower than one bit.
  function automatic int stage_w(input int n_points);
    int w;
    w = $clog2($clog2(n_points));
    return (w < 1) ? 1 : w;
  endfunction

  // Butterfly index spans 0..N/2-1.
  function automatic int bfly_w(input int n_points);
    return $clog2(n_points) - 1;
  endfunction

  // In stage s only the low s bits of the butterfly index select a distinct
  // twiddle; scaling by 2^(stages-1-s) maps it onto the N/2-entry ROM.
  function automatic int unsigned tw_index(input int unsigned stage,
                                           input int unsigned bfly,
                                           input int unsigned stages);
    int unsigned mask;
    mask = (32'd1 << stage) - 32'd1;
    return (bfly & mask) << (stages - 32'd1 - stage);
  endfunction

endpackage

// File: rtl/fft_tw_addr_gen.sv
// fft_tw_addr_gen
//   Combinational twiddle ROM address generator, shared by the forward and
//   inverse FFT controllers.
//   Parameters: N_POINTS - FFT size (power of two, 4..1024).
//   Ports:
//     stage   in  [SW-1:0]  current stage index
//     bfly    in  [BW-1:0]  butterfly index within the stage
//     tw_addr out [BW-1:0]  twiddle ROM address
module fft_tw_addr_gen
  import fft_pkg::*;
#(
  parameter  int N_POINTS = 16,
  localparam int STAGES   = $clog2(N_POINTS),
  localparam int SW       = stage_w(N_POINTS),
  localparam int BW       = bfly_w(N_POINTS)
) (
  input  logic [SW-1:0] stage,
  input  logic [BW-1:0] bfly,
  output logic [BW-1:0] tw_addr
);

  assign tw_addr = BW'(tw_index(32'(stage), 32'(bfly), unsigned'(STAGES)));

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Control unit for an N-point radix-2 DIT FFT datapath. Walks every
//   butterfly of every stage, then waits PIPE_LAT cycles for the butterfly
//   pipeline to empty before pulsing o_done.
//   Optional build macro: FFT_SEQ_AUTO_RESTART_EN - when defined, i_start seen
//   in the completion cycle starts the next frame directly (no idle cycle).
//   Parameters: N_POINTS (4..1024, power of two), PIPE_LAT (>= 0).
//   Ports:
//     i_clk      in   clock, rising edge
//     i_rst_n    in   synchronous active-low reset
//     i_start    in   frame start request (acted on in idle only)
//     i_en       in   issue enable; low freezes the stage/butterfly counters
//     o_busy     out  issuing or draining
//     o_valid    out  a butterfly is issued this cycle
//     o_mux_sel  out  current stage index
//     o_bfly     out  butterfly index within the stage
//     o_tw_addr  out  twiddle ROM address
//     o_last     out  final butterfly of the final stage issued this cycle
//     o_done     out  one-cycle frame-complete pulse
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter  int N_POINTS = 16,
  parameter  int PIPE_LAT = 2,
  localparam int STAGES   = $clog2(N_POINTS),
  localparam int SW       = stage_w(N_POINTS),
  localparam int BW       = bfly_w(N_POINTS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_en,
  output logic          o_busy,
  output logic          o_valid,
  output logic [SW-1:0] o_mux_sel,
  output logic [BW-1:0] o_bfly,
  output logic [BW-1:0] o_tw_addr,
  output logic          o_last,
  output logic          o_done
);

  // Drain counter runs 0..PIPE_LAT-1.
  localparam int DW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
  localparam logic [BW-1:0] LAST_BFLY  = BW'(N_POINTS / 2 - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  fft_state_e    state_reg, state_next;
  logic [SW-1:0] stage_reg, stage_next;
  logic [BW-1:0] bfly_reg,  bfly_next;
  logic [DW-1:0] drain_reg, drain_next;

  // Counters as seen by the datapath: forced to zero outside RUN.
  logic [SW-1:0] run_stage;
  logic [BW-1:0] run_bfly;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      stage_reg <= '0;
      bfly_reg  <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      bfly_reg  <= bfly_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    bfly_next  = bfly_reg;
    drain_next = drain_reg;
    o_busy     = 1'b0;
    o_valid    = 1'b0;
    o_last     = 1'b0;
    o_done     = 1'b0;
    run_stage  = '0;
    run_bfly   = '0;

    case (state_reg)
      ST_IDLE: begin
        stage_next = '0;
        bfly_next  = '0;
        drain_next = '0;
        if (i_start) state_next = ST_RUN;
      end

      ST_RUN: begin
        o_busy    = 1'b1;
        run_stage = stage_reg;
        run_bfly  = bfly_reg;
        if (i_en) begin
          o_valid = 1'b1;
          if (bfly_reg == LAST_BFLY) begin
            bfly_next = '0;
            if (stage_reg == LAST_STAGE) begin
              o_last     = 1'b1;
              stage_next = '0;
              drain_next = '0;
              // With no pipeline latency there is nothing to wait for.
              state_next = (PIPE_LAT == 0) ? ST_DONE : ST_DRAIN;
            end else begin
              stage_next = stage_reg + SW'(1);
            end
          end else begin
            bfly_next = bfly_reg + BW'(1);
          end
        end
      end

      ST_DRAIN: begin
        // Drain runs on wall-clock cycles; i_en only gates issue.
        o_busy = 1'b1;
        if (drain_reg == LAST_DRAIN) begin
          drain_next = '0;
          state_next = ST_DONE;
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end

      ST_DONE: begin
        o_done     = 1'b1;
        stage_next = '0;
        bfly_next  = '0;
        drain_next = '0;
`ifdef FFT_SEQ_AUTO_RESTART_EN
        state_next = i_start ? ST_RUN : ST_IDLE;
`else
        state_next = ST_IDLE;
`endif
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign o_mux_sel = run_stage;
  assign o_bfly    = run_bfly;

  fft_tw_addr_gen #(
    .N_POINTS (N_POINTS)
  ) u_tw_addr_gen (
    .stage   (run_stage),
    .bfly    (run_bfly),
    .tw_addr (o_tw_addr)
  );

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Parametrised control unit for an N-point radix-2 DIT FFT datapath.
- Steps through every stage and every butterfly within each stage, and drives these datapath controls: stage select (mux select), butterfly index and twiddle ROM address.
- Supports repeated frames via a start/done handshake, stall via enable, and a pipeline drain phase.
- Sits between the frame buffer/top-level controller and the butterfly/twiddle datapath.

Parameters:
- N_POINTS, 16, FFT size; power of two, 4..1024.
- PIPE_LAT, 2, butterfly pipeline latency in cycles waited after the last issue before done; 0 allowed.
- STAGES, $clog2(N_POINTS), derived localparam; not overridable.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  frame start request; sampled only in IDLE.
- i_en  in  1  issue enable; 0 stalls the butterfly/stage counters.
- o_busy  out  1  high in RUN and DRAIN.
- o_valid  out  1  high when a butterfly is issued this cycle (RUN and i_en).
- o_mux_sel  out  SW=max(1,$clog2(STAGES))  current stage index, 0..STAGES-1.
- o_bfly  out  BW=STAGES-1  butterfly index within stage, 0..N/2-1.
- o_tw_addr  out  BW  twiddle ROM address.
- o_last  out  1  high with o_valid on the final butterfly of the final stage.
- o_done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (i_rst_n low at an edge):
  - State goes to IDLE; all counters are zeroed.
  - All outputs go to 0.
  - Reset mid-frame aborts the frame with no o_done.
- FSM transitions:
  - IDLE -> RUN on i_start=1.
  - RUN -> DRAIN after the last butterfly issue, or RUN -> DONE if PIPE_LAT=0.
  - DRAIN -> DONE after PIPE_LAT cycles.
  - DONE -> IDLE.
- RUN, counter rules:
  - On entry, stage=0 and bfly=0.
  - Each cycle with i_en=1, the current (stage, bfly) is issued with o_valid=1, then bfly increments.
  - When bfly=N/2-1, bfly wraps to 0 and stage increments.
  - Issue at stage=STAGES-1, bfly=N/2-1 raises o_last and leaves RUN.
  - i_en=0 holds all counters and drives o_valid=0.
- Twiddle address: o_tw_addr = (bfly mod 2^stage) << (STAGES-1-stage), width BW, combinational from the counters.
- Outside RUN: o_mux_sel, o_bfly and o_tw_addr are held at 0.
- DRAIN: the drain counter ignores i_en; o_valid=0; o_busy=1.
- DONE: o_done=1 for exactly one cycle; o_busy=0.
- i_start in any state except IDLE (or DONE under the optional feature) is ignored, not queued.
- Latency, with i_en held high: the start edge is E0; issues occupy cycles 1..STAGES*N/2; o_done is high in cycle STAGES*N/2+PIPE_LAT+1. For the defaults that is cycle 35.
- Stall cycles extend RUN one-for-one.

Optional Feature:
- Macro: FFT_SEQ_AUTO_RESTART_EN.
- Defined: in DONE, if i_start=1, the next state is RUN (counters zeroed) instead of IDLE. This allows back-to-back frames with one bubble cycle; o_done still pulses.
- Undefined: DONE always returns to IDLE, and i_start in DONE is ignored.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the function for the twiddle-index computation;
  - width helper functions (stage width, butterfly width).
- One sub-module: fft_tw_addr_gen, combinational (stage, bfly) -> o_tw_addr, reused by the inverse-FFT controller.

Test Plan:
- Reset: hold i_rst_n=0 for 3 edges with i_start=1 -> all outputs 0, state IDLE; release -> no activity until i_start is sampled.
- Nominal N=16, PIPE_LAT=2, i_en=1:
  - single i_start pulse -> exactly 32 o_valid cycles;
  - o_mux_sel steps 0,1,2,3, each value held for 8 cycles;
  - o_last in cycle 32; o_done only in cycle 35.
- Twiddle check:
  - stage0 -> all 0;
  - stage2 bfly5 -> 2;
  - stage3 bfly7 -> 7;
  - stage1 bfly3 -> 4.
- Stall: drop i_en for 5 cycles during stage 1 -> counters frozen, o_valid=0; o_done in cycle 40; total o_valid count still 32.
- Abort and ignore:
  - i_rst_n=0 at stage 2 -> outputs 0, no o_done;
  - i_start pulses during RUN/DRAIN -> ignored; exactly one o_done per accepted frame.
- Back-to-back: i_start held high; with FFT_SEQ_AUTO_RESTART_EN -> next RUN begins the cycle after DONE; without it -> one IDLE cycle between frames.
